// File: rtl/stopwatch_core_if.sv
// stopwatch_core control/display bundle.
// Master drives tick and buttons; slave drives digits and flags.
interface stopwatch_core_if;
  logic       tick_100Hz;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] cs_ones;
  logic [3:0] cs_tens;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       lap_active;
  logic       overflow;

  modport master (
    output tick_100Hz, start_stop, clear, lap,
    input  cs_ones, cs_tens, sec_ones, sec_tens,
    input  min_ones, min_tens,
    input  running, lap_active, overflow
  );

  modport slave (
    input  tick_100Hz, start_stop, clear, lap,
    output cs_ones, cs_tens, sec_ones, sec_tens,
    output min_ones, min_tens,
    output running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD mm:ss.cc timekeeper with run/pause/clear.
// Lap latch built only when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
  parameter int unsigned MAX_MIN_TENS = 5
) (
  input logic CLK_50_MHz,
  input logic reset_n,
  stopwatch_core_if.slave sw
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  // digit index 0 = cs_ones ... 5 = min_tens
  localparam logic [5:0][3:0] LIM = {
    4'(MAX_MIN_TENS), 4'd9, 4'd5, 4'd9, 4'd9, 4'd9
  };

  state_e state_q, state_d;
  logic [5:0][3:0] cnt_q, cnt_d;
  logic [5:0][3:0] inc;
  logic [5:0][3:0] disp;
  logic ovf_q, ovf_d;
  logic wrap;
  logic count_en;

  assign count_en = (state_q == S_RUN) && sw.tick_100Hz;

  // BCD increment cascade; saturating compare keeps digits legal
  always_comb begin
    logic carry;
    inc = cnt_q;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (cnt_q[i] >= LIM[i]) begin
          inc[i] = 4'd0;
        end else begin
          inc[i] = cnt_q[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  // next state, count and sticky overflow
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (sw.clear) begin
      state_d = S_IDLE;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (count_en) begin
        cnt_d = inc;
        if (wrap) ovf_d = 1'b1;
      end
      if (sw.start_stop) begin
        unique case (state_q)
          S_IDLE:  state_d = S_RUN;
          S_RUN:   state_d = S_PAUSE;
          S_PAUSE: state_d = S_RUN;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // core state registers
  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_q, lap_d;
  logic [5:0][3:0] latch_q, latch_d;

  // lap toggle: freeze pre-increment count, or release
  always_comb begin
    lap_d = lap_q;
    latch_d = latch_q;
    if (sw.clear) begin
      lap_d = 1'b0;
    end else if (sw.lap && !sw.start_stop) begin
      if (lap_q) begin
        lap_d = 1'b0;
      end else if (state_q == S_RUN) begin
        lap_d = 1'b1;
        latch_d = cnt_q;
      end
    end
  end

  // lap latch registers
  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      lap_q <= 1'b0;
      latch_q <= '0;
    end else begin
      lap_q <= lap_d;
      latch_q <= latch_d;
    end
  end

  assign disp = lap_q ? latch_q : cnt_q;
  assign sw.lap_active = lap_q;
`else
  logic unused_lap;
  assign unused_lap = sw.lap;
  assign disp = cnt_q;
  assign sw.lap_active = 1'b0;
`endif

  assign sw.cs_ones  = disp[0];
  assign sw.cs_tens  = disp[1];
  assign sw.sec_ones = disp[2];
  assign sw.sec_tens = disp[3];
  assign sw.min_ones = disp[4];
  assign sw.min_tens = disp[5];
  assign sw.running  = (state_q == S_RUN);
  assign sw.overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core.
// Runs with MAX_MIN_TENS=0 so the wrap is 09:59.99 -> 00:00.00.
module tb_stopwatch_core;

  logic clk;
  logic rst_n;
  int n_cmp;
  int n_bad;

  stopwatch_core_if sw_if ();

  stopwatch_core #(
    .MAX_MIN_TENS(0)
  ) dut (
    .CLK_50_MHz(clk),
    .reset_n(rst_n),
    .sw(sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  function automatic logic [23:0] digits();
    return {sw_if.min_tens, sw_if.min_ones,
            sw_if.sec_tens, sw_if.sec_ones,
            sw_if.cs_tens, sw_if.cs_ones};
  endfunction

  task automatic check(input string tag,
                       input logic [23:0] got,
                       input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic ss,
                     input logic cl, input logic lp);
    sw_if.tick_100Hz = t;
    sw_if.start_stop = ss;
    sw_if.clear = cl;
    sw_if.lap = lp;
    @(posedge clk);
    #1;
    sw_if.tick_100Hz = 1'b0;
    sw_if.start_stop = 1'b0;
    sw_if.clear = 1'b0;
    sw_if.lap = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sw_if.tick_100Hz = 1'b0;
    sw_if.start_stop = 1'b0;
    sw_if.clear = 1'b0;
    sw_if.lap = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_digits", digits(), 24'h000000);
    check("rst_running", 24'(sw_if.running), 24'd0);
    check("rst_lap", 24'(sw_if.lap_active), 24'd0);
    check("rst_ovf", 24'(sw_if.overflow), 24'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // start then 100 ticks -> 00:01.00
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("start_running", 24'(sw_if.running), 24'd1);
    ticks(100);
    check("run100", digits(), 24'h000100);
    check("run100_running", 24'(sw_if.running), 24'd1);

    // pause with same-cycle tick
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("clear1", digits(), 24'h000000);
    check("clear1_running", 24'(sw_if.running), 24'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(37);
    check("at37", digits(), 24'h000037);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("pause_tick", digits(), 24'h000038);
    check("pause_running", 24'(sw_if.running), 24'd0);
    ticks(10);
    check("paused_hold", digits(), 24'h000038);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("resume_notick", digits(), 24'h000038);
    check("resume_running", 24'(sw_if.running), 24'd1);
    ticks(2);
    check("resumed", digits(), 24'h000040);

    // clear beats start_stop and tick
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1234);
    check("at1234", digits(), 24'h001234);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("clrpri_digits", digits(), 24'h000000);
    check("clrpri_running", 24'(sw_if.running), 24'd0);
    ticks(3);
    check("idle_hold", digits(), 24'h000000);

    // lap freeze and release
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(500);
    check("at500", digits(), 24'h000500);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_set", 24'(sw_if.lap_active), 24'(LAP));
    ticks(250);
    check("lap_frozen", digits(), LAP ? 24'h000500 : 24'h000750);
    check("lap_hold_flag", 24'(sw_if.lap_active), 24'(LAP));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_release", digits(), 24'h000750);
    check("lap_rel_flag", 24'(sw_if.lap_active), 24'd0);

    // lap with same-cycle tick latches pre-increment count
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("lap_tick", digits(), LAP ? 24'h000005 : 24'h000006);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_tick_rel", digits(), 24'h000006);

    // lap ignored while paused
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_paused", 24'(sw_if.lap_active), 24'd0);

    // wrap 09:59.99 -> 00:00.00 sets sticky overflow
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(6000);
    check("at1min", digits(), 24'h010000);
    ticks(53999);
    check("at_max", digits(), 24'h095999);
    check("ovf_pre", 24'(sw_if.overflow), 24'd0);
    ticks(1);
    check("wrap", digits(), 24'h000000);
    check("ovf_set", 24'(sw_if.overflow), 24'd1);
    ticks(5);
    check("post_wrap", digits(), 24'h000005);
    check("ovf_sticky", 24'(sw_if.overflow), 24'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("ovf_pause", 24'(sw_if.overflow), 24'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("ovf_clear", 24'(sw_if.overflow), 24'd0);

    // asynchronous reset between edges
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_areset", digits(), 24'h000003);
    #2;
    sw_if.tick_100Hz = 1'b1;
    rst_n = 1'b0;
    #1;
    check("areset_digits", digits(), 24'h000000);
    check("areset_running", 24'(sw_if.running), 24'd0);
    check("areset_lap", 24'(sw_if.lap_active), 24'd0);
    sw_if.tick_100Hz = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_rst", digits(), 24'h000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
